pipeline_stage_reg: RTL and testbench

//  Generic elastic pipeline register for inter-stage boundaries (EX/MEM first user); successor of fixed stage regs.

---
 rtl/pipe_reg_pkg.sv | 46 ++++
 rtl/pipeline_stage_reg_slot.sv | 77 +++++++
 rtl/pipeline_stage_reg.sv | 239 +++++++++++++++++++++++
 tb/tb_pipeline_stage_reg.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_reg_pkg
//   Shared definitions for the elastic pipeline stage register.
//   - Control-vector field layout (bit offsets and widths) for the EX/MEM
//     control bundle carried through the stage.
//   - Stage occupancy state codes used by pipeline_stage_reg.
//   - Default parameter values.
// -----------------------------------------------------------------------------
package pipe_reg_pkg;

  // Default geometry of the stage payload.
  localparam int PIPE_DATA_W_DEF   = 32;
  localparam int PIPE_NUM_DATA_DEF = 3;
  localparam int PIPE_CTRL_W_DEF   = 11;
  localparam int PIPE_ADDR_W_DEF   = 5;

  // Control vector field layout.
  localparam int CTRL_BRANCH_RES_BIT = 0;
  localparam int CTRL_REG_DEST_BIT   = 1;
  localparam int CTRL_REG_WRITE_BIT  = 2;
  localparam int CTRL_MEM_READ_LSB   = 3;
  localparam int CTRL_MEM_READ_W     = 3;
  localparam int CTRL_MEM_WRITE_LSB  = 6;
  localparam int CTRL_MEM_WRITE_W    = 3;
  localparam int CTRL_MEM_TO_REG_LSB = 9;
  localparam int CTRL_MEM_TO_REG_W   = 2;

  // Same layout as a packed struct, MSB field first.
  typedef struct packed {
    logic [CTRL_MEM_TO_REG_W-1:0] mem_to_reg;
    logic [CTRL_MEM_WRITE_W-1:0]  mem_write;
    logic [CTRL_MEM_READ_W-1:0]   mem_read;
    logic                         reg_write;
    logic                         reg_dest;
    logic                         branch_res;
  } ctrl_fields_t;

  // Stage occupancy: EMPTY (no entry), ONE (main entry valid),
  // FULL (main and skid entries valid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } stage_state_e;

endpackage : pipe_reg_pkg

// File: rtl/pipeline_stage_reg_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
//   One storage entry of the elastic stage: valid flag plus control vector,
//   destination address and packed data words.
//   Ports:
//     clk_i    clock, rising edge
//     rst_ni   asynchronous active-low reset (entry invalid, contents zero)
//     clear_i  synchronous clear: entry invalid, contents zero (wins over load)
//     load_i   capture ctrl_i/addr_i/data_i and mark the entry valid
//     ctrl_i, addr_i, data_i   payload to capture
//     valid_o, ctrl_o, addr_o, data_o   stored entry
//   With neither clear_i nor load_i the entry holds.
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_reg_pkg::*;
#(
  parameter int DATA_W   = PIPE_DATA_W_DEF,
  parameter int NUM_DATA = PIPE_NUM_DATA_DEF,
  parameter int CTRL_W   = PIPE_CTRL_W_DEF,
  parameter int ADDR_W   = PIPE_ADDR_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       load_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [NUM_DATA*DATA_W-1:0] data_i,
  output logic                       valid_o,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [ADDR_W-1:0]          addr_o,
  output logic [NUM_DATA*DATA_W-1:0] data_o
);

  logic                       valid_q, valid_d;
  logic [CTRL_W-1:0]          ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [NUM_DATA*DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      addr_d  = '0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      addr_d  = addr_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule : pipe_slot

// File: rtl/pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_reg
//   Elastic pipeline register for an inter-stage boundary. Carries a control
//   vector, a destination register address and NUM_DATA data words with a
//   valid/ready handshake and a two-entry skid (main entry M drives the
//   outputs, skid entry S catches the beat accepted while M is stuck).
//   Ports:
//     CLK, RESET_N          clock (rising edge), async active-low reset
//     BUSY_WAIT             global stall: every register holds
//     FLUSH                 synchronous squash of both entries
//     IN_VALID/IN_READY     upstream handshake; IN_READY never depends on
//                           OUT_READY, so there is no comb path in->out
//     IN_CTRL/IN_ADDRESS/IN_DATA    incoming beat (word 0 in LSBs)
//     OUT_VALID/OUT_READY   downstream handshake
//     OUT_CTRL/OUT_ADDRESS/OUT_DATA outgoing beat, all zero when OUT_VALID=0
//     STALL_CNT, BUBBLE_CNT saturating 16-bit event counters
//   Build option: define PIPE_REG_PERF_EN to add STALL_CNT/BUBBLE_CNT ports
//   and their counters; without it those ports and logic are absent.
// -----------------------------------------------------------------------------
module pipeline_stage_reg
  import pipe_reg_pkg::*;
#(
  parameter int DATA_W   = PIPE_DATA_W_DEF,
  parameter int NUM_DATA = PIPE_NUM_DATA_DEF,
  parameter int CTRL_W   = PIPE_CTRL_W_DEF,
  parameter int ADDR_W   = PIPE_ADDR_W_DEF
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       BUSY_WAIT,
  input  logic                       FLUSH,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [CTRL_W-1:0]          IN_CTRL,
  input  logic [ADDR_W-1:0]          IN_ADDRESS,
  input  logic [NUM_DATA*DATA_W-1:0] IN_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [CTRL_W-1:0]          OUT_CTRL,
  output logic [ADDR_W-1:0]          OUT_ADDRESS,
  output logic [NUM_DATA*DATA_W-1:0] OUT_DATA
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [15:0]                STALL_CNT,
  output logic [15:0]                BUBBLE_CNT
`endif
);

  localparam int DW = NUM_DATA * DATA_W;

  stage_state_e state_q, state_d;

  // Cleared by reset, set on the first clock after release. Gating IN_READY
  // with this flop keeps the stage from accepting while RESET_N is low
  // without feeding the reset net into the handshake logic.
  logic rdy_en_q;

  logic acc, drn;

  // Entry control strobes
  logic m_load, m_clear, m_from_s;
  logic s_load, s_clear;

  // Entry contents
  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;
  logic [ADDR_W-1:0] m_addr, s_addr, m_addr_in;
  logic [DW-1:0]     m_data, s_data, m_data_in;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign IN_READY = rdy_en_q & (state_q != ST_FULL) & ~BUSY_WAIT & ~FLUSH;
  assign acc      = IN_VALID & IN_READY;
  // A flushed cycle never counts as a delivered beat.
  assign drn      = m_valid & OUT_READY & ~BUSY_WAIT & ~FLUSH;

  // ---------------------------------------------------------------------------
  // Occupancy FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_EMPTY;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // BUSY_WAIT needs no branch of its own: it forces acc=drn=0, so every
  // state falls through to hold.
  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_clear  = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clear  = 1'b0;
    if (FLUSH) begin
      state_d = ST_EMPTY;
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            m_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && drn) begin
            m_load = 1'b1;
          end else if (acc) begin
            // M is stuck: the new beat parks behind it in S.
            state_d = ST_FULL;
            s_load  = 1'b1;
          end else if (drn) begin
            state_d = ST_EMPTY;
            m_clear = 1'b1;
          end
        end
        ST_FULL: begin
          // IN_READY is low here, so only the older S beat can move up.
          if (drn) begin
            state_d  = ST_ONE;
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clear  = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          m_clear = 1'b1;
          s_clear = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entries
  // ---------------------------------------------------------------------------
  assign m_ctrl_in = m_from_s ? s_ctrl : IN_CTRL;
  assign m_addr_in = m_from_s ? s_addr : IN_ADDRESS;
  assign m_data_in = m_from_s ? s_data : IN_DATA;

  pipe_slot #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .CTRL_W   (CTRL_W),
    .ADDR_W   (ADDR_W)
  ) u_slot_m (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .clear_i (m_clear),
    .load_i  (m_load),
    .ctrl_i  (m_ctrl_in),
    .addr_i  (m_addr_in),
    .data_i  (m_data_in),
    .valid_o (m_valid),
    .ctrl_o  (m_ctrl),
    .addr_o  (m_addr),
    .data_o  (m_data)
  );

  pipe_slot #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .CTRL_W   (CTRL_W),
    .ADDR_W   (ADDR_W)
  ) u_slot_s (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .clear_i (s_clear),
    .load_i  (s_load),
    .ctrl_i  (IN_CTRL),
    .addr_i  (IN_ADDRESS),
    .data_i  (IN_DATA),
    .valid_o (s_valid),
    .ctrl_o  (s_ctrl),
    .addr_o  (s_addr),
    .data_o  (s_data)
  );

  // ---------------------------------------------------------------------------
  // Outputs: a bubble carries no payload, so downstream side effects
  // (register write, memory access) are impossible on an invalid beat.
  // ---------------------------------------------------------------------------
  assign OUT_VALID   = m_valid;
  assign OUT_CTRL    = m_valid ? m_ctrl : '0;
  assign OUT_ADDRESS = m_valid ? m_addr : '0;
  assign OUT_DATA    = m_valid ? m_data : '0;

  // s_valid is implied by state_q == ST_FULL; it is only observed here so
  // the skid entry's flag stays visible for debug.
  logic skid_unused;
  assign skid_unused = s_valid;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_REG_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        stall_evt, bubble_evt;

  assign stall_evt  = BUSY_WAIT | (m_valid & ~OUT_READY);
  assign bubble_evt = ~m_valid;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (bubble_evt && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign STALL_CNT  = stall_cnt_q;
  assign BUBBLE_CNT = bubble_cnt_q;
`else
  // Counters not built: the stage has no event-count state.
`endif

endmodule : pipeline_stage_reg

// File: tb/tb_pipeline_stage_reg.sv
module tb_pipeline_stage_reg;

  localparam int DATA_W   = 32;
  localparam int NUM_DATA = 3;
  localparam int CTRL_W   = 11;
  localparam int ADDR_W   = 5;
  localparam int DW       = DATA_W * NUM_DATA;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              BUSY_WAIT;
  logic              FLUSH;
  logic              IN_VALID;
  logic              IN_READY;
  logic [CTRL_W-1:0] IN_CTRL;
  logic [ADDR_W-1:0] IN_ADDRESS;
  logic [DW-1:0]     IN_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [CTRL_W-1:0] OUT_CTRL;
  logic [ADDR_W-1:0] OUT_ADDRESS;
  logic [DW-1:0]     OUT_DATA;
`ifdef PIPE_REG_PERF_EN
  logic [15:0]       STALL_CNT;
  logic [15:0]       BUBBLE_CNT;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } beat_t;

  always #5 CLK = ~CLK;

  pipeline_stage_reg #(
    .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BUSY_WAIT(BUSY_WAIT), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CTRL(IN_CTRL),
    .IN_ADDRESS(IN_ADDRESS), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CTRL(OUT_CTRL),
    .OUT_ADDRESS(OUT_ADDRESS), .OUT_DATA(OUT_DATA)
`ifdef PIPE_REG_PERF_EN
    , .STALL_CNT(STALL_CNT), .BUBBLE_CNT(BUBBLE_CNT)
`endif
  );

  // Inputs change just after a falling edge; outputs are read there too.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive_beat(input logic v, input beat_t b);
    IN_VALID   = v;
    IN_CTRL    = b.ctrl;
    IN_ADDRESS = b.addr;
    IN_DATA    = b.data;
  endtask

  function automatic beat_t mk(input logic [CTRL_W-1:0] c, input logic [ADDR_W-1:0] a,
                               input logic [31:0] w2, input logic [31:0] w1, input logic [31:0] w0);
    beat_t b;
    b.ctrl = c;
    b.addr = a;
    b.data = {w2, w1, w0};
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    beat_t b;
    b = mk(11'h7FF, 5'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    OUT_READY = 1'b0;
    drive_beat(1'b1, b);
    tick();
    tests_run++;
    if (OUT_VALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_preload: OUT_VALID=%0b want 1", OUT_VALID);
    end
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    tests_run++;
    if (OUT_VALID !== 1'b0 || OUT_CTRL !== '0 || OUT_ADDRESS !== '0 || OUT_DATA !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%0b ctrl=%h addr=%h data=%h want all 0",
               OUT_VALID, OUT_CTRL, OUT_ADDRESS, OUT_DATA);
    end
    tests_run++;
    if (IN_READY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready: IN_READY=%0b want 0", IN_READY);
    end
    drive_beat(1'b0, '0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    tests_run++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: IN_READY=%0b OUT_VALID=%0b want 1/0", IN_READY, OUT_VALID);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_pass_through();
    beat_t b;
    b = mk(11'h0DD, 5'd4, 32'd10, 32'd42, 32'd56);
    OUT_READY = 1'b1;
    drive_beat(1'b1, b);
    #1;
    tests_run++;
    if (IN_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL pass_in_ready: IN_READY=%0b want 1", IN_READY);
    end
    tick();
    tests_run++;
    if (OUT_VALID !== 1'b1 || OUT_CTRL !== b.ctrl || OUT_ADDRESS !== b.addr || OUT_DATA !== b.data) begin
      tests_failed++;
      $display("FAIL pass_out: valid=%0b ctrl=%h addr=%h data=%h want 1 %h %h %h",
               OUT_VALID, OUT_CTRL, OUT_ADDRESS, OUT_DATA, b.ctrl, b.addr, b.data);
    end
    drive_beat(1'b0, '0);
    tick();
    tests_run++;
    if (OUT_VALID !== 1'b0 || OUT_CTRL !== '0) begin
      tests_failed++;
      $display("FAIL pass_bubble: valid=%0b ctrl=%h want 0 0", OUT_VALID, OUT_CTRL);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    beat_t a, b;
    a = mk(11'h0A5, 5'd3, 32'd1, 32'd2, 32'd56);
    b = mk(11'h15A, 5'd9, 32'd7, 32'd8, 32'd6);
    OUT_READY = 1'b0;
    drive_beat(1'b1, a);
    tick();
    drive_beat(1'b1, b);
    #1;
    tests_run++;
    if (IN_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_one: IN_READY=%0b want 1", IN_READY);
    end
    tick();
    drive_beat(1'b0, '0);
    #1;
    tests_run++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT_DATA !== a.data) begin
      tests_failed++;
      $display("FAIL bp_full: IN_READY=%0b valid=%0b data=%h want 0 1 %h",
               IN_READY, OUT_VALID, OUT_DATA, a.data);
    end
    OUT_READY = 1'b1;
    tick();
    tests_run++;
    if (OUT_VALID !== 1'b1 || OUT_CTRL !== b.ctrl || OUT_ADDRESS !== b.addr || OUT_DATA !== b.data) begin
      tests_failed++;
      $display("FAIL bp_second: valid=%0b ctrl=%h addr=%h data=%h want B",
               OUT_VALID, OUT_CTRL, OUT_ADDRESS, OUT_DATA);
    end
    tick();
    tests_run++;
    if (OUT_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: valid=%0b want 0", OUT_VALID);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_busy_wait();
    beat_t a, c;
    a = mk(11'h123, 5'd7, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003);
    c = mk(11'h321, 5'd17, 32'hCCCC_0001, 32'hCCCC_0002, 32'hCCCC_0003);
    OUT_READY = 1'b0;
    drive_beat(1'b1, a);
    tick();
    drive_beat(1'b1, c);
    BUSY_WAIT = 1'b1;
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (IN_READY !== 1'b0) begin
        tests_failed++;
        $display("FAIL busy_in_ready[%0d]: IN_READY=%0b want 0", i, IN_READY);
      end
      tick();
      tests_run++;
      if (OUT_VALID !== 1'b1 || OUT_CTRL !== a.ctrl || OUT_ADDRESS !== a.addr || OUT_DATA !== a.data) begin
        tests_failed++;
        $display("FAIL busy_hold[%0d]: valid=%0b ctrl=%h addr=%h data=%h want A",
                 i, OUT_VALID, OUT_CTRL, OUT_ADDRESS, OUT_DATA);
      end
    end
    BUSY_WAIT = 1'b0;
    tick();
    drive_beat(1'b0, '0);
    tests_run++;
    if (OUT_VALID !== 1'b1 || OUT_CTRL !== c.ctrl || OUT_DATA !== c.data) begin
      tests_failed++;
      $display("FAIL busy_release: valid=%0b ctrl=%h data=%h want C", OUT_VALID, OUT_CTRL, OUT_DATA);
    end
    tick();
    tests_run++;
    if (OUT_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_no_dup: valid=%0b want 0", OUT_VALID);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    OUT_READY = 1'b0;
    drive_beat(1'b1, mk(11'h7FF, 5'd1, 32'd11, 32'd12, 32'd13));
    tick();
    drive_beat(1'b1, mk(11'h7FE, 5'd2, 32'd21, 32'd22, 32'd23));
    tick();
    BUSY_WAIT = 1'b1;
    FLUSH     = 1'b1;
    OUT_READY = 1'b1;
    drive_beat(1'b1, mk(11'h555, 5'd3, 32'd31, 32'd32, 32'd33));
    #1;
    tests_run++;
    if (IN_READY !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_in_ready: IN_READY=%0b want 0", IN_READY);
    end
    tick();
    FLUSH = 1'b0;
    drive_beat(1'b0, '0);
    #1;
    tests_run++;
    if (OUT_VALID !== 1'b0 || OUT_CTRL !== '0 || OUT_DATA !== '0 || IN_READY !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_out: valid=%0b ctrl=%h data=%h in_ready=%0b want 0 0 0 0",
               OUT_VALID, OUT_CTRL, OUT_DATA, IN_READY);
    end
    BUSY_WAIT = 1'b0;
    #1;
    tests_run++;
    if (IN_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_release: IN_READY=%0b want 1", IN_READY);
    end
    tick();
    tests_run++;
    if (OUT_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_leak: valid=%0b want 0", OUT_VALID);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference: the stage behaves as a FIFO of at most two beats whose head is
  // what the outputs show.
  task automatic test_random();
    beat_t q[$];
    beat_t nb, exp_b;
    logic  exp_rdy, acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      nb.ctrl = CTRL_W'($urandom_range(0, 2047));
      nb.addr = ADDR_W'($urandom_range(0, 31));
      nb.data = {$urandom, $urandom, $urandom};
      drive_beat($urandom_range(0, 3) != 0, nb);
      OUT_READY = $urandom_range(0, 2) != 0;
      BUSY_WAIT = $urandom_range(0, 7) == 0;
      FLUSH     = $urandom_range(0, 24) == 0;
      #1;
      exp_b   = (q.size() != 0) ? q[0] : '0;
      exp_rdy = (q.size() < 2) && !BUSY_WAIT && !FLUSH;
      tests_run++;
      if (OUT_VALID !== (q.size() != 0) || OUT_CTRL !== exp_b.ctrl ||
          OUT_ADDRESS !== exp_b.addr || OUT_DATA !== exp_b.data || IN_READY !== exp_rdy) begin
        tests_failed++;
        $display("FAIL random[%0d]: valid=%0b rdy=%0b ctrl=%h addr=%h data=%h want %0b %0b %h %h %h",
                 cyc, OUT_VALID, IN_READY, OUT_CTRL, OUT_ADDRESS, OUT_DATA,
                 q.size() != 0, exp_rdy, exp_b.ctrl, exp_b.addr, exp_b.data);
      end
      acc = IN_VALID && exp_rdy;
      if (FLUSH) begin
        q.delete();
      end else if (!BUSY_WAIT) begin
        if (q.size() != 0 && OUT_READY) void'(q.pop_front());
        if (acc) q.push_back(nb);
      end
      tick();
    end
    FLUSH     = 1'b1;
    BUSY_WAIT = 1'b0;
    drive_beat(1'b0, '0);
    tick();
    FLUSH = 1'b0;
  endtask

`ifdef PIPE_REG_PERF_EN
  task automatic test_perf();
    drive_beat(1'b0, '0);
    OUT_READY = 1'b0;
    BUSY_WAIT = 1'b0;
    FLUSH     = 1'b0;
    RESET_N   = 1'b0;
    #1;
    tests_run++;
    if (STALL_CNT !== 16'd0 || BUBBLE_CNT !== 16'd0) begin
      tests_failed++;
      $display("FAIL perf_reset: stall=%0d bubble=%0d want 0 0", STALL_CNT, BUBBLE_CNT);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();                                   // empty: bubble 1
    drive_beat(1'b1, mk(11'h001, 5'd1, 32'd1, 32'd2, 32'd3));
    tick();                                   // empty while accepting: bubble 2
    drive_beat(1'b0, '0);
    repeat (5) tick();                        // valid, not ready: stall 5
    OUT_READY = 1'b1;
    tick();                                   // delivered: neither
    tick();                                   // empty: bubble 3
    tests_run++;
    if (STALL_CNT !== 16'd5 || BUBBLE_CNT !== 16'd3) begin
      tests_failed++;
      $display("FAIL perf_count: stall=%0d bubble=%0d want 5 3", STALL_CNT, BUBBLE_CNT);
    end
    BUSY_WAIT = 1'b1;
    repeat (70000) @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (STALL_CNT !== 16'hFFFF || BUBBLE_CNT !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL perf_saturate: stall=%h bubble=%h want ffff ffff", STALL_CNT, BUBBLE_CNT);
    end
    BUSY_WAIT = 1'b0;
  endtask
`endif

  // ---------------------------------------------------------------------------
  initial begin
    RESET_N   = 1'b0;
    BUSY_WAIT = 1'b0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b0;
    drive_beat(1'b0, '0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    tick();

    test_reset();
    test_pass_through();
    test_backpressure();
    test_busy_wait();
    test_flush();
    test_random();
`ifdef PIPE_REG_PERF_EN
    test_perf();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pipeline_stage_reg
